// File: rtl/llc_cache_pkg.sv
// Shared types and constants for the last-level cache model: geometry, MESI,
// bus/snoop/L1 message enums and trace opcodes.
package LLC_defs;
    localparam int NUM_SETS      = 16384;
    localparam int ASSOCIATIVITY = 16;
    localparam int TAG_W         = 12;
    localparam int INDEX_W       = 14;
    localparam int OFFSET_W      = 6;
    localparam int WAY_W         = 4;
    localparam int PLRU_W        = ASSOCIATIVITY - 1;

    localparam int OP_RD       = 0;
    localparam int OP_WR       = 1;
    localparam int OP_IRD      = 2;
    localparam int OP_SNP_RD   = 3;
    localparam int OP_SNP_WR   = 4;
    localparam int OP_SNP_RWIM = 5;
    localparam int OP_SNP_INV  = 6;
    localparam int OP_CLEAR    = 8;
    localparam int OP_DUMP     = 9;

    typedef enum logic [1:0] {I, S, E, M} mesi_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        mesi_t            mesi;
    } cache;

    typedef enum logic [2:0] {NOBUS, READ, WRITE, INVALIDATE, RWIM} busOperation;
    typedef enum logic [1:0] {NOHIT, HIT, HITM} snoopResults;
    typedef enum logic [2:0] {NOMSG, GETLINE, SENDLINE, INVALIDATELINE, EVICTLINE} messages;

    // Other caches' response to our bus READ is faked from the low address bits.
    function automatic snoopResults sim_snoop(input logic [1:0] lo);
        case (lo)
            2'b00:   return HIT;
            2'b01:   return HITM;
            default: return NOHIT;
        endcase
    endfunction
endpackage

// File: rtl/llc_cache_plru_tree.sv
// 16-way tree pseudo-LRU: heap-ordered node bits, 1 = victim lies to the right.
module plru_tree
    import LLC_defs::*;
(
    input  logic [PLRU_W-1:0] state,
    input  logic [WAY_W-1:0]  way,
    output logic [PLRU_W-1:0] state_nxt,
    output logic [WAY_W-1:0]  victim
);
    logic b3, b2, b1, b0;

    assign b3 = state[0];
    assign b2 = state[4'd1 + 4'(b3)];
    assign b1 = state[4'd3 + 4'({b3, b2})];
    assign b0 = state[4'd7 + 4'({b3, b2, b1})];
    assign victim = {b3, b2, b1, b0};

    // Each node on the accessed path is pointed at the opposite subtree.
    always_comb begin
        state_nxt = state;
        state_nxt[0]                    = ~way[3];
        state_nxt[4'd1 + 4'(way[3])]    = ~way[2];
        state_nxt[4'd3 + 4'(way[3:2])]  = ~way[1];
        state_nxt[4'd7 + 4'(way[3:1])]  = ~way[0];
    end
endmodule

// File: rtl/llc_cache.sv
// Trace-driven LLC model: one op per clock, MESI state per way, tree PLRU per set,
// registered bus/snoop/message results and hit/miss statistics.
module llc_cache
    import LLC_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  int          op,
    output int          cacheRds,
    output int          cacheWrs,
    output int          cacheHits,
    output int          cacheMisses,
    output busOperation busOp,
    output snoopResults snoopResult,
    output messages     message,
    output cache        LLC_cache [NUM_SETS][ASSOCIATIVITY]
);
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tg;
    logic [PLRU_W-1:0]  plru [NUM_SETS];
    logic [PLRU_W-1:0]  plru_upd;
    logic [WAY_W-1:0]   hit_way, inv_way, victim, fill_way, acc_way, way_sel;
    logic               hit, has_inv;
    logic               line_we, touch, rd_inc, wr_inc, hit_inc, miss_inc;
    cache               cur_line, fill_line, line_nxt;
    busOperation        bus_nxt;
    snoopResults        snp_nxt, sim_snp;
    messages            msg_nxt;
    logic               unused_ok;

    assign idx       = addr[OFFSET_W +: INDEX_W];
    assign tg        = addr[31 -: TAG_W];
    assign sim_snp   = sim_snoop(addr[1:0]);
    assign unused_ok = ^addr[5:2];

    // Lowest-index match wins for both the hit and the free-way search.
    always_comb begin : lookup
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (LLC_cache[idx][w].valid && LLC_cache[idx][w].mesi != I &&
                LLC_cache[idx][w].tag == tg) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!LLC_cache[idx][w].valid) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign fill_way  = has_inv ? inv_way : victim;
    assign acc_way   = hit ? hit_way : fill_way;
    assign cur_line  = LLC_cache[idx][hit_way];
    assign fill_line = LLC_cache[idx][fill_way];

    plru_tree u_plru (
        .state     (plru[idx]),
        .way       (acc_way),
        .state_nxt (plru_upd),
        .victim    (victim)
    );

    always_comb begin : decode
        bus_nxt  = NOBUS;
        snp_nxt  = NOHIT;
        msg_nxt  = NOMSG;
        line_we  = 1'b0;
        way_sel  = hit_way;
        line_nxt = cur_line;
        touch    = 1'b0;
        rd_inc   = 1'b0;
        wr_inc   = 1'b0;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        case (op)
            OP_RD, OP_IRD: begin
                rd_inc  = 1'b1;
                touch   = 1'b1;
                msg_nxt = SENDLINE;
                if (hit) begin
                    hit_inc = 1'b1;
                end else begin
                    miss_inc = 1'b1;
                    bus_nxt  = READ;
                    snp_nxt  = sim_snp;
                    line_we  = 1'b1;
                    way_sel  = fill_way;
                    line_nxt = '{valid: 1'b1, tag: tg, mesi: (sim_snp == NOHIT) ? E : S};
                end
            end
            OP_WR: begin
                wr_inc  = 1'b1;
                touch   = 1'b1;
                msg_nxt = SENDLINE;
                line_we = 1'b1;
                if (hit) begin
                    hit_inc = 1'b1;
                    if (cur_line.mesi == S) bus_nxt = INVALIDATE;
                    line_nxt.mesi = M;
                end else begin
                    miss_inc = 1'b1;
                    bus_nxt  = RWIM;
                    way_sel  = fill_way;
                    line_nxt = '{valid: 1'b1, tag: tg, mesi: M};
                end
            end
            OP_SNP_RD: if (hit) begin
                line_we       = 1'b1;
                line_nxt.mesi = S;
                if (cur_line.mesi == M) begin
                    snp_nxt = HITM;
                    bus_nxt = WRITE;
                    msg_nxt = GETLINE;
                end else begin
                    snp_nxt = HIT;
                end
            end
            OP_SNP_RWIM: if (hit) begin
                line_we        = 1'b1;
                line_nxt.valid = 1'b0;
                line_nxt.mesi  = I;
                if (cur_line.mesi == M) begin
                    snp_nxt = HITM;
                    bus_nxt = WRITE;
                    msg_nxt = EVICTLINE;
                end else begin
                    snp_nxt = HIT;
                    msg_nxt = INVALIDATELINE;
                end
            end
            OP_SNP_INV: if (hit && cur_line.mesi == S) begin
                line_we        = 1'b1;
                line_nxt.valid = 1'b0;
                line_nxt.mesi  = I;
                snp_nxt        = HIT;
                msg_nxt        = INVALIDATELINE;
            end
            OP_SNP_WR, OP_DUMP: ;
            default: ;
        endcase
        // Eviction notice only surfaces when nothing else claims the message slot.
        if (line_we && !hit && fill_line.valid && msg_nxt == NOMSG) msg_nxt = EVICTLINE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || op == OP_CLEAR) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                plru[s] <= '0;
                for (int w = 0; w < ASSOCIATIVITY; w++) LLC_cache[s][w] <= '0;
            end
            cacheRds    <= 0;
            cacheWrs    <= 0;
            cacheHits   <= 0;
            cacheMisses <= 0;
            busOp       <= NOBUS;
            snoopResult <= NOHIT;
            message     <= NOMSG;
        end else begin
            busOp       <= bus_nxt;
            snoopResult <= snp_nxt;
            message     <= msg_nxt;
            if (line_we)  LLC_cache[idx][way_sel] <= line_nxt;
            if (touch)    plru[idx]   <= plru_upd;
            if (rd_inc)   cacheRds    <= cacheRds + 1;
            if (wr_inc)   cacheWrs    <= cacheWrs + 1;
            if (hit_inc)  cacheHits   <= cacheHits + 1;
            if (miss_inc) cacheMisses <= cacheMisses + 1;
        end
    end
endmodule

// File: tb/tb_llc_cache.sv
// Directed trace bench for llc_cache: expected results are queued as each op is
// driven and compared one cycle later, when the registered outputs appear.
module tb_llc_cache;
    import LLC_defs::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    int          op;
    int          cacheRds, cacheWrs, cacheHits, cacheMisses;
    busOperation busOp;
    snoopResults snoopResult;
    messages     message;
    cache        llc [NUM_SETS][ASSOCIATIVITY];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        busOperation bus;
        snoopResults snp;
        messages     msg;
        int          rds, wrs, hits, misses;
        bit          has_line;
        int          set, way;
        bit          valid;
        logic [11:0] tag;
        mesi_t       mesi;
    } exp_t;

    exp_t sb[$];

    llc_cache dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .op          (op),
        .cacheRds    (cacheRds),
        .cacheWrs    (cacheWrs),
        .cacheHits   (cacheHits),
        .cacheMisses (cacheMisses),
        .busOp       (busOp),
        .snoopResult (snoopResult),
        .message     (message),
        .LLC_cache   (llc)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(busOperation b, snoopResults s, messages m,
                                int r, int w, int h, int mi);
        exp_t e;
        e.bus = b; e.snp = s; e.msg = m;
        e.rds = r; e.wrs = w; e.hits = h; e.misses = mi;
        e.has_line = 1'b0; e.set = 0; e.way = 0;
        e.valid = 1'b0; e.tag = '0; e.mesi = I;
        return e;
    endfunction

    function automatic exp_t ln(exp_t e0, int st, int wy, bit v, logic [11:0] t, mesi_t ms);
        exp_t e = e0;
        e.has_line = 1'b1; e.set = st; e.way = wy;
        e.valid = v; e.tag = t; e.mesi = ms;
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, expv);
        end
    endtask

    task automatic pop_check(string nm);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty", nm);
            return;
        end
        e = sb.pop_front();
        chk({nm, ".busOp"},       32'(busOp),       32'(e.bus));
        chk({nm, ".snoopResult"}, 32'(snoopResult), 32'(e.snp));
        chk({nm, ".message"},     32'(message),     32'(e.msg));
        chk({nm, ".cacheRds"},    cacheRds,         e.rds);
        chk({nm, ".cacheWrs"},    cacheWrs,         e.wrs);
        chk({nm, ".cacheHits"},   cacheHits,        e.hits);
        chk({nm, ".cacheMisses"}, cacheMisses,      e.misses);
        if (e.has_line) begin
            chk({nm, ".valid"}, 32'(llc[e.set][e.way].valid), 32'(e.valid));
            chk({nm, ".mesi"},  32'(llc[e.set][e.way].mesi),  32'(e.mesi));
            if (e.valid) chk({nm, ".tag"}, 32'(llc[e.set][e.way].tag), 32'(e.tag));
        end
    endtask

    // Drive one op for a single cycle, then idle and compare the result.
    task automatic step(string nm, int o, logic [31:0] a, exp_t e);
        @(negedge clk);
        op   = o;
        addr = a;
        sb.push_back(e);
        @(negedge clk);
        op = 7;
        pop_check(nm);
    endtask

    task automatic chk_valid_count(string nm, int st, int expn);
        int n;
        n = 0;
        for (int w = 0; w < ASSOCIATIVITY; w++) n += int'(llc[st][w].valid);
        chk(nm, n, expn);
    endtask

    initial begin
        logic [11:0] t;
        int          wy;

        rst_n = 1'b0;
        op    = 7;
        addr  = '0;
        repeat (3) @(negedge clk);
        sb.push_back(ln(ex(NOBUS, NOHIT, NOMSG, 0, 0, 0, 0), 'h676, 0, 1'b0, '0, I));
        pop_check("reset");
        rst_n = 1'b1;

        step("rd_miss",  0, 32'h10019D94, ln(ex(READ, HIT, SENDLINE, 1, 0, 0, 1), 'h676, 0, 1'b1, 12'h100, S));
        step("rd_hit",   0, 32'h10019D94, ln(ex(NOBUS, NOHIT, SENDLINE, 2, 0, 1, 1), 'h676, 0, 1'b1, 12'h100, S));
        step("wr_hit_s", 1, 32'h10019D94, ln(ex(INVALIDATE, NOHIT, SENDLINE, 2, 1, 2, 1), 'h676, 0, 1'b1, 12'h100, M));
        step("snp_rd_m", 3, 32'h10019D94, ln(ex(WRITE, HITM, GETLINE, 2, 1, 2, 1), 'h676, 0, 1'b1, 12'h100, S));
        step("snp_wr",   4, 32'h10019D94, ln(ex(NOBUS, NOHIT, NOMSG, 2, 1, 2, 1), 'h676, 0, 1'b1, 12'h100, S));
        step("snp_inv",  6, 32'h10019D94, ln(ex(NOBUS, HIT, INVALIDATELINE, 2, 1, 2, 1), 'h676, 0, 1'b0, '0, I));

        // Fill all 16 ways of set 0x676, then one more miss evicts the PLRU way 0.
        for (int i = 0; i < 17; i++) begin
            t  = 12'h200 + 12'(i);
            wy = (i == 16) ? 0 : i;
            step($sformatf("fill%0d", i), 0, {t, 20'h19D82},
                 ln(ex(READ, NOHIT, SENDLINE, 3 + i, 1, 2, 2 + i), 'h676, wy, 1'b1, t, E));
        end
        chk("keep_way1", 32'(llc['h676][1].tag), 32'h201);
        chk_valid_count("valid_after_evict", 'h676, 16);

        step("ird_hit",    2, {12'h205, 20'h19D82}, ln(ex(NOBUS, NOHIT, SENDLINE, 20, 1, 3, 18), 'h676, 5, 1'b1, 12'h205, E));
        step("rwim_e",     5, {12'h203, 20'h19D82}, ln(ex(NOBUS, HIT, INVALIDATELINE, 20, 1, 3, 18), 'h676, 3, 1'b0, '0, I));
        step("snp_rd_e",   3, {12'h204, 20'h19D82}, ln(ex(NOBUS, HIT, NOMSG, 20, 1, 3, 18), 'h676, 4, 1'b1, 12'h204, S));
        step("snp_inv_e",  6, {12'h205, 20'h19D82}, ln(ex(NOBUS, NOHIT, NOMSG, 20, 1, 3, 18), 'h676, 5, 1'b1, 12'h205, E));
        step("wr_miss",    1, 32'h20000002, ln(ex(RWIM, NOHIT, SENDLINE, 20, 2, 3, 19), 0, 0, 1'b1, 12'h200, M));
        step("rwim_m",     5, 32'h20000002, ln(ex(WRITE, HITM, EVICTLINE, 20, 2, 3, 19), 0, 0, 1'b0, '0, I));
        step("dump",       9, 32'h10019D94, ln(ex(NOBUS, NOHIT, NOMSG, 20, 2, 3, 19), 'h676, 0, 1'b1, 12'h210, E));
        step("clear",      8, 32'h10019D94, ln(ex(NOBUS, NOHIT, NOMSG, 0, 0, 0, 0), 'h676, 0, 1'b0, '0, I));
        chk_valid_count("valid_after_clear", 'h676, 0);
        step("rd_miss_hm", 0, 32'h30000041, ln(ex(READ, HITM, SENDLINE, 1, 0, 0, 1), 1, 0, 1'b1, 12'h300, S));

        // Reset asserted together with a live write must win over it.
        @(negedge clk);
        op    = 1;
        addr  = 32'h30000041;
        rst_n = 1'b0;
        sb.push_back(ln(ex(NOBUS, NOHIT, NOMSG, 0, 0, 0, 0), 1, 0, 1'b0, '0, I));
        @(negedge clk);
        rst_n = 1'b1;
        op    = 7;
        pop_check("mid_reset");
        chk_valid_count("valid_after_reset", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
